// File: rtl/reg_bank_pipe.sv
// reg_bank_pipe: CHANNELS x WIDTH shadow register bank with per-lane write
// enables, feeding a DEPTH-stage elastic valid/ready pipeline.
// Optional feature: define REG_BANK_PIPE_CLR_EN to add the synchronous `clr`
// input. Without it, only `reset` clears state.
module reg_bank_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS*WIDTH-1:0]     data,
  input  logic [CHANNELS-1:0]           enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CHANNELS*WIDTH-1:0]     outa,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
`ifdef REG_BANK_PIPE_CLR_EN
  ,
  input  logic                          clr
`endif
);

  localparam int unsigned DW    = CHANNELS * WIDTH;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  // Stage index 0 is the entry stage, DEPTH-1 is the head driving outa.
  logic [DW-1:0]    shadow_q;
  logic [DW-1:0]    merged;
  logic [DW-1:0]    stage_d [DEPTH];
  logic [DEPTH-1:0] stage_v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH:0]   adv;
  logic [OCC_W-1:0] occ_next;
  logic             accept;
  logic             clear_i;

`ifdef REG_BANK_PIPE_CLR_EN
  assign clear_i = clr;
`else
  assign clear_i = 1'b0;
`endif

  // Per-lane merge: enabled lanes take the new data, others keep the shadow.
  always_comb begin
    merged = shadow_q;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (enable[c]) begin
        merged[c*WIDTH +: WIDTH] = data[c*WIDTH +: WIDTH];
      end
    end
  end

  // Load-enable chain: a stage loads when it is empty or its successor moves.
  always_comb begin
    logic run;
    adv        = '0;
    run        = out_ready;
    adv[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      adv[i] = !stage_v[i] || run;
      run    = adv[i];
    end
  end

  // Handshake: ready while reset is held; forced low during a clear.
  assign in_ready = reset || (adv[0] && !clear_i);
  assign accept   = in_valid && adv[0] && !clear_i;

  // Next valid bits and their popcount for the registered occupancy.
  always_comb begin
    v_next   = stage_v;
    occ_next = '0;
    if (adv[0]) begin
      v_next[0] = accept;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (adv[i]) begin
        v_next[i] = stage_v[i-1];
      end
    end
    if (clear_i) begin
      v_next = '0;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_next = occ_next + OCC_W'(v_next[i]);
    end
  end

  // Shadow bank: updated only by accepted beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (clear_i) begin
      shadow_q <= '0;
    end else if (accept) begin
      shadow_q <= merged;
    end
  end

  // Valid chain and occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_v   <= '0;
      occupancy <= '0;
    end else begin
      stage_v   <= v_next;
      occupancy <= occ_next;
    end
  end

  // Data chain: a stage only captures valid upstream data, so the head holds
  // its last value while out_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_d[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_d[i] <= '0;
      end
    end else begin
      if (accept) begin
        stage_d[0] <= merged;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i] && stage_v[i-1]) begin
          stage_d[i] <= stage_d[i-1];
        end
      end
    end
  end

  assign outa      = stage_d[DEPTH-1];
  assign out_valid = stage_v[DEPTH-1];

endmodule

// File: tb/tb_reg_bank_pipe.sv
// Bench for reg_bank_pipe: directed steps plus randomized traffic checked
// against a queue-based model of shadow merges and in-flight beats.
module tb_reg_bank_pipe;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned DW       = WIDTH * CHANNELS;
  localparam int unsigned OCC_W    = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic [DW-1:0]     data;
  logic [CHANNELS-1:0] enable;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     outa;
  logic              out_valid;
  logic              out_ready;
  logic [OCC_W-1:0]  occupancy;
  logic              clr_m;

  reg_bank_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outa      (outa),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef REG_BANK_PIPE_CLR_EN
    ,
    .clr       (clr_m)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: lane array, queue of in-flight words with their ages.
  logic [WIDTH-1:0] shadow_m [CHANNELS];
  logic [DW-1:0]    q_data [$];
  int               q_age  [$];
  logic [DW-1:0]    last_head;
  logic             acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < int'(CHANNELS); c++) shadow_m[c] = '0;
    q_data.delete();
    q_age.delete();
    last_head = '0;
  endtask

  // One clock cycle: drive, check at the falling edge, update model at rise.
  task automatic do_cycle(input logic iv, input logic [CHANNELS-1:0] en,
                          input logic [DW-1:0] dat, input logic ordy,
                          input logic cl, output logic accepted);
    logic          exp_ov;
    logic          exp_rdy;
    logic          pop;
    logic [DW-1:0] word;
    in_valid  = iv;
    enable    = en;
    data      = dat;
    out_ready = ordy;
    clr_m     = cl;
    @(negedge clk);
    exp_ov = 1'b0;
    if (q_data.size() > 0) exp_ov = (q_age[0] >= int'(DEPTH) - 1);
    exp_rdy = !cl && !(q_data.size() == int'(DEPTH) && !ordy);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("outa", 64'(outa), exp_ov ? 64'(q_data[0]) : 64'(last_head));
    chk("occupancy", 64'(occupancy), 64'(q_data.size()));
    accepted = iv && exp_rdy;
    pop      = exp_ov && ordy;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      word[c*WIDTH +: WIDTH] = en[c] ? dat[c*WIDTH +: WIDTH] : shadow_m[c];
    end
    @(posedge clk);
    if (cl) begin
      model_clear();
    end else begin
      if (pop) begin
        last_head = q_data.pop_front();
        void'(q_age.pop_front());
      end
      foreach (q_age[j]) q_age[j]++;
      if (accepted) begin
        for (int c = 0; c < int'(CHANNELS); c++) shadow_m[c] = word[c*WIDTH +: WIDTH];
        q_data.push_back(word);
        q_age.push_back(0);
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int cyc = 0; cyc < 20 && q_data.size() > 0; cyc++) begin
      do_cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    end
    chk("drain_occ", 64'(occupancy), 64'd0);
  endtask

  logic [DW-1:0]       s_dat [6];
  logic [CHANNELS-1:0] s_en  [6];
  int                  idx;
  int                  nacc;

  initial begin
    model_clear();
    reset     = 1'b1;
    in_valid  = 1'b1;
    enable    = '1;
    data      = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    clr_m     = 1'b0;

    // Reset state; a beat offered during reset must be ignored.
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outa", 64'(outa), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // First beat: visible two edges after accept.
    do_cycle(1'b1, 4'b1111, 32'h4433_2211, 1'b1, 1'b0, acc);
    chk("lat_occ_n", 64'(occupancy), 64'd1);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_outa", 64'(outa), 64'h4433_2211);
    chk("lat_occ_n1", 64'(occupancy), 64'd1);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("lat_occ_n2", 64'(occupancy), 64'd0);

    // Partial-enable merge.
    do_cycle(1'b1, 4'b0101, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("merge_0101", 64'(outa), 64'h44FF_22FF);
    drain();

    // Stream six beats against a stalled consumer, then release it.
    for (int i = 0; i < 6; i++) begin
      s_dat[i] = DW'($urandom);
      s_en[i]  = CHANNELS'($urandom);
    end
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      do_cycle(1'b1, s_en[idx], s_dat[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("stall_occ", 64'(occupancy), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      do_cycle(1'b1, s_en[idx], s_dat[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    chk("stream_sent", 64'(idx), 64'd6);
    drain();

    // Random traffic with random consumer back-pressure.
    nacc = 0;
    for (int cyc = 0; cyc < 3000 && nacc < 200; cyc++) begin
      do_cycle(1'($urandom_range(0, 9) < 7), CHANNELS'($urandom), DW'($urandom),
               1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) nacc++;
    end
    chk("rand_beats", 64'(nacc), 64'd200);
    drain();

    // Reset with two beats in flight.
    do_cycle(1'b1, 4'b1111, 32'h1234_5678, 1'b0, 1'b0, acc);
    do_cycle(1'b1, 4'b1111, 32'h9ABC_DEF0, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_outa", 64'(outa), 64'd0);
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_cycle(1'b1, 4'b0001, 32'h5566_77AA, 1'b1, 1'b0, acc);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_outa", 64'(outa), 64'h0000_00AA);
    drain();

`ifdef REG_BANK_PIPE_CLR_EN
    // Clear while full drops the simultaneous beat and zeroes the shadow.
    do_cycle(1'b1, 4'b1111, 32'hA1A2_A3A4, 1'b0, 1'b0, acc);
    do_cycle(1'b1, 4'b1111, 32'hB1B2_B3B4, 1'b0, 1'b0, acc);
    do_cycle(1'b1, 4'b1111, 32'hC1C2_C3C4, 1'b1, 1'b1, acc);
    chk("clr_occ", 64'(occupancy), 64'd0);
    chk("clr_outa", 64'(outa), 64'd0);
    do_cycle(1'b1, 4'b0001, 32'hEEEE_EE55, 1'b1, 1'b0, acc);
    do_cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("clr_merge", 64'(outa), 64'h0000_0055);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_pipe.md
# reg_bank_pipe

Parametrised successor to the single-lane enable register. Holds `CHANNELS` lanes of `WIDTH`-bit held values. Updates only the lanes whose enable bit is set on an accepted input beat, and carries each merged word through a `DEPTH`-stage elastic pipeline with valid/ready flow control. It sits between the stimulus driver and the scoreboard-visible output in the register testbench, and replaces the fixed-width, unbuffered register.

## Interface
Parameters:
- `WIDTH`, 8 — bits per lane.
- `CHANNELS`, 4 — number of lanes (≥1).
- `DEPTH`, 2 — pipeline stages between accept and output (≥1).

Ports:
- `clk`  input  1  — single clock; all state updates on its rising edge.
- `reset`  input  1  — asynchronous, active-high reset.
- `data`  input  `CHANNELS*WIDTH`  — lane c occupies bits `[c*WIDTH +: WIDTH]`.
- `enable`  input  `CHANNELS`  — per-lane write enable, sampled on accept.
- `in_valid`  input  1  — input beat present.
- `in_ready`  output  1  — block can accept a beat this cycle.
- `outa`  output  `CHANNELS*WIDTH`  — merged word at the pipeline head.
- `out_valid`  output  1  — `outa` is valid.
- `out_ready`  input  1  — consumer takes `outa` this cycle.
- `occupancy`  output  `$clog2(DEPTH+1)`  — number of valid stages.
- `clr`  input  1  — present only with `REG_BANK_PIPE_CLR_EN`.

## Operation
- Shadow bank: `CHANNELS` registers `shadow[c]`, each `WIDTH` bits.
- Accept occurs when `in_valid && in_ready`. On accept, for each lane c: `shadow[c] <= enable[c] ? data[c] : shadow[c]`.
- The merged word enters stage 1 on the same edge. Lanes with `enable[c]=0` carry the prior `shadow[c]`. Lanes with `enable[c]=1` carry the new `data[c]`.
- Stage k (1..DEPTH) has a valid bit `v[k]` and a data register `d[k]`. Stage DEPTH drives `outa` and `out_valid`.
- Advance rule: `adv[DEPTH+1] = out_ready`. Stage k loads from stage k-1 (stage 0 = the input beat) when `!v[k] || adv[k+1]`.
- When a stage advances and its upstream is not valid, `v[k]` clears. Data in an invalid stage is don't-care but must not reach `outa` while `out_valid=0`. Instead `outa` holds its last value.
- `in_ready = !v[1] || adv[2]`. This is a combinational path from `out_ready` through the valid chain, with no registered skid.
- `occupancy` is the registered popcount of `v[1..DEPTH]`.
- Sequence with no enable set at any lane: the output equals shadow, i.e. all zeros after reset.
- Shadow is never modified by an unaccepted beat, whatever `enable` is.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): `shadow`=0, all `v`=0, all `d`=0, `outa`=0, `out_valid`=0, `occupancy`=0.
- While `reset` is high, `in_ready`=1. Beats presented during reset are not accepted.
- Latency: a beat accepted at edge N appears with `out_valid=1` after edge N+DEPTH-1, i.e. visible in cycle N+DEPTH, provided the pipeline is not stalled.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Stall: when `out_valid && !out_ready`, `outa` and `out_valid` hold stable. Upstream stages fill bubbles. `in_ready` falls only when all DEPTH stages are valid and the head is stalled.
- Full pipeline with `out_ready=1` and `in_valid=1` on the same cycle: output pop and input push both occur, and `occupancy` stays at DEPTH.
- Reset mid-stream: all in-flight beats are discarded and shadow is zeroed immediately.

## Configuration
- `REG_BANK_PIPE_CLR_EN` defined: adds input `clr`, a synchronous clear.
  - When `clr=1` at an edge, `shadow`, all `v`, and `occupancy` go to 0, and `outa` goes to 0.
  - `clr` has priority over a simultaneous accept, which is dropped.
  - `in_ready` is forced to 0 during `clr`.
- Macro undefined: the `clr` port and its logic are absent. Only `reset` clears state.

## Test plan
- Reset, then one beat `data`=0x44_33_22_11, `enable`=4'b1111, `out_ready`=1 (WIDTH=8, CHANNELS=4, DEPTH=2) -> `outa`=0x44332211 with `out_valid`=1 exactly 2 cycles after accept; `occupancy` goes 1, 1, 0.
- Follow with `data`=0xFFFFFFFF, `enable`=4'b0101 -> `outa`=0x44FF22FF.
- Stream 6 beats with `out_ready`=0 -> `in_ready` drops after 2 accepts and `occupancy`=2. Raise `out_ready` -> the remaining 4 beats emerge in order, 1 per cycle, with no loss or duplication.
- Random `out_ready` toggling over 200 beats with random `enable` -> output sequence matches a reference model of shadow merges, and `outa` never changes while `out_valid && !out_ready`.
- Assert `reset` with 2 beats in flight -> `out_valid`=0 and `outa`=0 immediately. The next beat with `enable`=4'b0001, `data`=0xAA -> `outa`=0x000000AA.
- With `REG_BANK_PIPE_CLR_EN`: pulse `clr` together with `in_valid` while full -> `occupancy`=0 next cycle, the beat is dropped, and the following merge uses a zeroed shadow.
